// File: rtl/jt6295_mix.sv
// jt6295_mix: voice mixer and optional linear upsampler for the JT6295 core.
//
// CH time-multiplexed voice samples are summed into one frame. The frame sum
// is scaled by an unsigned 4.4 gain and saturated to WO bits. With INTERPOL=1,
// CH output samples per frame are produced by interpolating linearly from the
// previous frame value to the current one. With INTERPOL=0, one sample is
// produced per frame.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset, clears every register
//   cen_sl     slot strobe, one voice sample per strobe
//   cen        frame start, only honoured together with cen_sl
//   gain       unsigned 4.4 gain, 16 = unity
//   sound_in   signed voice sample, valid on cen_sl
//   sound_out  signed mixed output
//   sample     one-cycle pulse whenever sound_out updates
//   clip       the last latched frame was saturated
module jt6295_mix #(
    parameter int CH       = 4,
    parameter int WI       = 12,
    parameter int WO       = 16,
    parameter int INTERPOL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen_sl,
    input  logic                 cen,
    input  logic [7:0]           gain,
    input  logic signed [WI-1:0] sound_in,
    output logic signed [WO-1:0] sound_out,
    output logic                 sample,
    output logic                 clip
);
    localparam int L  = $clog2(CH);
    localparam int AW = WI + L;
    localparam int PW = AW + 9;
    localparam int RW = WO + L + 2;

    localparam logic signed [PW-1:0] QMAX = {{(PW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [PW-1:0] QMIN = {{(PW-WO+1){1'b1}}, {(WO-1){1'b0}}};
    localparam logic signed [WO-1:0] OMAX = {1'b0, {(WO-1){1'b1}}};
    localparam logic signed [WO-1:0] OMIN = {1'b1, {(WO-1){1'b0}}};
    localparam logic [L:0]           KMAX = (L+1)'(CH);
    localparam logic [L:0]           KONE = (L+1)'(1);

    logic                 frame;
    logic signed [AW-1:0] ext_in;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic                 armed;
    logic [2:0]           sl_d;
    logic [2:0]           fr_d;
    logic signed [PW-1:0] prod_g;
    logic signed [PW-1:0] q;
    logic signed [WO-1:0] scaled;
    logic                 clip_n;
    logic signed [WO-1:0] prev;
    logic signed [WO-1:0] tgt;
    logic [L:0]           k;
    logic signed [WO-1:0] nprev;
    logic signed [WO-1:0] ntgt;
    logic [L:0]           nk;
    logic signed [WO:0]   diff;
    logic signed [RW-1:0] mul;
    logic signed [RW-1:0] step;
    logic signed [RW-1:0] pext;

    assign frame  = cen & cen_sl;
    assign ext_in = {{L{sound_in[WI-1]}}, sound_in};

    // Frame accumulator. The frame strobe slot starts the next frame, so the
    // finished sum is handed over before acc is reloaded. The very first
    // frame after reset is partial and is never handed over.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            sum   <= '0;
            armed <= 1'b0;
        end else if (cen_sl) begin
            if (cen) begin
                acc   <= ext_in;
                if (armed) sum <= acc;
                armed <= 1'b1;
            end else begin
                acc <= acc + ext_in;
            end
        end
    end

    // Strobe delay line; reset drops anything still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sl_d <= '0;
            fr_d <= '0;
        end else begin
            sl_d <= {sl_d[1:0], cen_sl};
            fr_d <= {fr_d[1:0], frame};
        end
    end

    // Gain product: gain is zero-extended so it always acts as a positive
    // multiplier; only the low PW bits of the product are needed.
    always_comb begin
        prod_g = {{9{sum[AW-1]}}, sum} * {{(PW-8){1'b0}}, gain};
        q      = prod_g >>> 4;
    end

    // Saturating scale stage, gain is only looked at one cycle after F.
    always_ff @(posedge clk) begin
        if (rst) begin
            scaled <= '0;
            clip_n <= 1'b0;
        end else if (fr_d[0]) begin
            if (q > QMAX) begin
                scaled <= OMAX;
                clip_n <= 1'b1;
            end else if (q < QMIN) begin
                scaled <= OMIN;
                clip_n <= 1'b1;
            end else begin
                scaled <= WO'(q);
                clip_n <= 1'b0;
            end
        end
    end

    // Interpolator next state. The output register is fed from the updated
    // prev/tgt/k so each slot reaches sound_out four cycles after its strobe.
    // k saturates at CH, where the step lands exactly on tgt.
    always_comb begin
        nprev = prev;
        ntgt  = tgt;
        nk    = k;
        if (sl_d[2]) begin
            if (fr_d[2]) begin
                nprev = tgt;
                ntgt  = scaled;
                nk    = KONE;
            end else if (k != KMAX) begin
                nk = k + KONE;
            end
        end
        diff = {ntgt[WO-1], ntgt} - {nprev[WO-1], nprev};
        mul  = {{(L+1){diff[WO]}}, diff} * {{(WO+1){1'b0}}, nk};
        step = mul >>> L;
        pext = {{(L+2){nprev[WO-1]}}, nprev};
    end

    // Output stage: one sample per frame, or one per slot when interpolating.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            tgt       <= '0;
            k         <= '0;
            sound_out <= '0;
            sample    <= 1'b0;
            clip      <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (INTERPOL != 0) begin
                prev <= nprev;
                tgt  <= ntgt;
                k    <= nk;
                if (sl_d[2]) begin
                    sound_out <= WO'(pext + step);
                    sample    <= 1'b1;
                end
                if (sl_d[2] & fr_d[2]) clip <= clip_n;
            end else if (sl_d[2] & fr_d[2]) begin
                sound_out <= scaled;
                clip      <= clip_n;
                sample    <= 1'b1;
            end
        end
    end
endmodule
